// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read channel between the fetch unit (master) and memory (slave).
// req/addr are held stable by the master from the raise of req until ack.
interface instr_fetch_unit_if #(
  parameter int PC_W    = 22,
  parameter int INSTR_W = 32
);
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/instr_fetch_unit.sv
// IF stage: owns the PC, fetches over the req/ack channel into a one-word buffer
// and presents it to IF/ID; branches abandon in-flight fetches via the DROP state.
module instr_fetch_unit #(
  parameter int                 PC_W     = 22,
  parameter int                 INSTR_W  = 32,
  parameter logic [PC_W-1:0]    RESET_PC = {PC_W{1'b0}},
  parameter logic [INSTR_W-1:0] NOP      = {INSTR_W{1'b0}}
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                hlt,
  input  logic                branch_taken,
  input  logic [PC_W-1:0]     branch_target,
  instr_fetch_unit_if.master  imem,
  output logic [INSTR_W-1:0]  instr_IF,
  output logic [PC_W-1:0]     PC_IF
);

  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_DROP = 1'b1} state_t;

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  state_t             state_r, state_nxt_s;
  logic [PC_W-1:0]    pc_r, pc_nxt_s;
  logic [PC_W-1:0]    req_addr_r, req_addr_nxt_s;
  logic [PC_W-1:0]    ibuf_pc_r, ibuf_pc_nxt_s;
  logic [INSTR_W-1:0] ibuf_r, ibuf_nxt_s;
  logic               pending_r, pending_nxt_s;
  logic               ibuf_valid_r, ibuf_valid_nxt_s;
  logic               accept_s, consumed_s, start_s, req_s, ack_s;
  logic [PC_W-1:0]    addr_s;

  // Handshake decode and buffer-driven outputs; rst gates req so it drops at once.
  always_comb begin
    accept_s      = !stall && !hlt;
    consumed_s    = ibuf_valid_r && accept_s;
    start_s       = (state_r == ST_RUN) && !pending_r && !hlt &&
                    (!ibuf_valid_r || consumed_s) && !rst;
    req_s         = pending_r || start_s;
    addr_s        = pending_r ? req_addr_r : pc_r;
    ack_s         = req_s && imem.imem_ack;
    imem.imem_req  = req_s;
    imem.imem_addr = addr_s;
    instr_IF      = ibuf_valid_r ? ibuf_r : NOP;
    PC_IF         = ibuf_valid_r ? ibuf_pc_r : {PC_W{1'b0}};
  end

  // Next-state: branch beats everything, and an unanswered request forces DROP.
  always_comb begin
    state_nxt_s      = state_r;
    pc_nxt_s         = pc_r;
    ibuf_nxt_s       = ibuf_r;
    ibuf_pc_nxt_s    = ibuf_pc_r;
    ibuf_valid_nxt_s = ibuf_valid_r;
    pending_nxt_s    = req_s && !ack_s;
    req_addr_nxt_s   = start_s ? pc_r : req_addr_r;
    if (branch_taken) begin
      pc_nxt_s         = branch_target;
      ibuf_valid_nxt_s = 1'b0;
      state_nxt_s      = (req_s && !ack_s) ? ST_DROP : ST_RUN;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (ack_s) begin
            ibuf_nxt_s       = imem.imem_rdata;
            ibuf_pc_nxt_s    = addr_s;
            ibuf_valid_nxt_s = 1'b1;
            pc_nxt_s         = pc_r + PC_ONE;
          end else if (consumed_s) begin
            ibuf_valid_nxt_s = 1'b0;
          end else begin
            ibuf_valid_nxt_s = ibuf_valid_r;
          end
        end
        ST_DROP: begin
          // The abandoned word is thrown away; fetching restarts from pc next cycle.
          if (ack_s) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_DROP;
          end
        end
        default: begin
          state_nxt_s      = ST_RUN;
          ibuf_valid_nxt_s = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_RUN;
      pc_r         <= RESET_PC;
      req_addr_r   <= RESET_PC;
      pending_r    <= 1'b0;
      ibuf_valid_r <= 1'b0;
      ibuf_r       <= NOP;
      ibuf_pc_r    <= {PC_W{1'b0}};
    end else begin
      state_r      <= state_nxt_s;
      pc_r         <= pc_nxt_s;
      req_addr_r   <= req_addr_nxt_s;
      pending_r    <= pending_nxt_s;
      ibuf_valid_r <= ibuf_valid_nxt_s;
      ibuf_r       <= ibuf_nxt_s;
      ibuf_pc_r    <= ibuf_pc_nxt_s;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table, hand-written corner sequences
// and a randomized run checked against a transaction-level stream model.
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP_W = 32'h0000_0000;

  logic        clk, rst, stall, hlt, branch_taken;
  logic [21:0] branch_target;
  logic [31:0] instr_IF;
  logic [21:0] PC_IF;

  instr_fetch_unit_if #(.PC_W(22), .INSTR_W(32)) bus ();

  instr_fetch_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .hlt(hlt),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem(bus), .instr_IF(instr_IF), .PC_IF(PC_IF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Memory contents: a scrambled address with bit 31 set, so a valid word never equals NOP.
  function automatic logic [31:0] mem_word(input logic [21:0] a);
    return 32'h8000_0000 | (({10'd0, a} * 32'h0001_3579) ^ 32'h1234_5678);
  endfunction

  // Memory responder: fixed wait states, or a per-cycle random ack.
  int wait_cfg = 0;
  int wait_cnt;
  bit rand_mode = 1'b0;
  bit rand_ack = 1'b0;

  always_comb begin
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'h0BAD_0BAD;
    if (bus.imem_req && (rand_mode ? rand_ack : (wait_cnt >= wait_cfg))) begin
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = mem_word(bus.imem_addr);
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) wait_cnt <= 0;
    else if (bus.imem_req && !bus.imem_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; hlt = 1'b0; branch_taken = 1'b0; branch_target = 22'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One cycle: drive inputs just after the edge, sample late in the cycle, advance.
  task automatic cyc(input string nm, input logic s, input logic h, input logic b,
                     input logic [21:0] t, input logic er, input logic [21:0] ea,
                     input logic ev, input logic [21:0] ep);
    stall = s; hlt = h; branch_taken = b; branch_target = t;
    #3;
    chk({nm, ".req"}, 64'(bus.imem_req), 64'(er));
    if (er) chk({nm, ".addr"}, 64'(bus.imem_addr), 64'(ea));
    if (ev) begin
      chk({nm, ".pc"}, 64'(PC_IF), 64'(ep));
      chk({nm, ".instr"}, 64'(instr_IF), 64'(mem_word(ep)));
    end else begin
      chk({nm, ".instr_nop"}, 64'(instr_IF), 64'(NOP_W));
      chk({nm, ".pc_zero"}, 64'(PC_IF), 64'd0);
    end
    @(posedge clk); #1;
    branch_taken = 1'b0;
  endtask

  typedef struct {
    logic        stall, hlt, br;
    logic [21:0] tgt;
    logic        req;
    logic [21:0] addr;
    logic        vld;
    logic [21:0] pc;
  } vec_t;

  vec_t tbl[14];

  // Random-phase model state.
  logic        prev_out, abandoned, hold, expect_load;
  logic [21:0] prev_addr, exp_pc, fetch_pc, hold_pc, load_pc;
  int          n_del;

  initial begin
    // Zero-wait stream with a stall, a branch coincident with ack, and a halt.
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 22'h0,   1'b1, 22'h0,   1'b0, 22'h0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 22'h0,   1'b1, 22'h1,   1'b1, 22'h0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 22'h0,   1'b1, 22'h2,   1'b1, 22'h1};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 22'h0,   1'b0, 22'h0,   1'b1, 22'h2};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 22'h0,   1'b0, 22'h0,   1'b1, 22'h2};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 22'h0,   1'b0, 22'h0,   1'b1, 22'h2};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 22'h0,   1'b1, 22'h3,   1'b1, 22'h2};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 22'h0,   1'b1, 22'h4,   1'b1, 22'h3};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 22'h100, 1'b1, 22'h5,   1'b1, 22'h4};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 22'h0,   1'b1, 22'h100, 1'b0, 22'h0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 22'h0,   1'b1, 22'h101, 1'b1, 22'h100};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 22'h0,   1'b0, 22'h0,   1'b1, 22'h101};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 22'h0,   1'b0, 22'h0,   1'b1, 22'h101};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 22'h0,   1'b1, 22'h102, 1'b1, 22'h101};

    rst = 1'b1; stall = 1'b0; hlt = 1'b0; branch_taken = 1'b0; branch_target = 22'd0;
    #2;
    chk("reset.req", 64'(bus.imem_req), 64'd0);
    chk("reset.instr", 64'(instr_IF), 64'(NOP_W));
    chk("reset.pc", 64'(PC_IF), 64'd0);

    do_reset();
    wait_cfg = 0;
    for (int i = 0; i < 14; i++)
      cyc($sformatf("tbl%0d", i), tbl[i].stall, tbl[i].hlt, tbl[i].br, tbl[i].tgt,
          tbl[i].req, tbl[i].addr, tbl[i].vld, tbl[i].pc);

    // Two wait states: NOP while waiting, address held, then the word.
    do_reset();
    wait_cfg = 2;
    cyc("ws0", 1'b0, 1'b0, 1'b0, 22'h0, 1'b1, 22'h0, 1'b0, 22'h0);
    cyc("ws1", 1'b0, 1'b0, 1'b0, 22'h0, 1'b1, 22'h0, 1'b0, 22'h0);
    cyc("ws2", 1'b0, 1'b0, 1'b0, 22'h0, 1'b1, 22'h0, 1'b0, 22'h0);
    cyc("ws3", 1'b0, 1'b0, 1'b0, 22'h0, 1'b1, 22'h1, 1'b1, 22'h0);

    // Branch coincident with ack, then branch while the fetch of 0x5 is pending.
    do_reset();
    wait_cfg = 0;
    cyc("bra0", 1'b0, 1'b0, 1'b1, 22'h5, 1'b1, 22'h0, 1'b0, 22'h0);
    wait_cfg = 3;
    cyc("bra1", 1'b0, 1'b0, 1'b0, 22'h0,   1'b1, 22'h5,   1'b0, 22'h0);
    cyc("drp0", 1'b0, 1'b0, 1'b1, 22'h100, 1'b1, 22'h5,   1'b0, 22'h0);
    cyc("drp1", 1'b0, 1'b0, 1'b0, 22'h0,   1'b1, 22'h5,   1'b0, 22'h0);
    cyc("drp2", 1'b0, 1'b0, 1'b0, 22'h0,   1'b1, 22'h5,   1'b0, 22'h0);
    wait_cfg = 0;
    cyc("drp3", 1'b0, 1'b0, 1'b0, 22'h0,   1'b1, 22'h100, 1'b0, 22'h0);
    cyc("drp4", 1'b0, 1'b0, 1'b0, 22'h0,   1'b1, 22'h101, 1'b1, 22'h100);

    // PC wrap at the top of the address space.
    cyc("wrp0", 1'b0, 1'b0, 1'b1, 22'h3FFFFF, 1'b1, 22'h102,    1'b1, 22'h101);
    cyc("wrp1", 1'b0, 1'b0, 1'b0, 22'h0,      1'b1, 22'h3FFFFF, 1'b0, 22'h0);
    cyc("wrp2", 1'b0, 1'b0, 1'b0, 22'h0,      1'b1, 22'h0,      1'b1, 22'h3FFFFF);
    wait_cfg = 2;
    cyc("wrp3", 1'b0, 1'b0, 1'b0, 22'h0,      1'b1, 22'h1,      1'b1, 22'h0);

    // Halt: the in-flight fetch still completes, no new request is made.
    cyc("hlt0", 1'b0, 1'b1, 1'b0, 22'h0, 1'b1, 22'h1, 1'b0, 22'h0);
    cyc("hlt1", 1'b0, 1'b1, 1'b0, 22'h0, 1'b1, 22'h1, 1'b0, 22'h0);
    cyc("hlt2", 1'b0, 1'b1, 1'b0, 22'h0, 1'b0, 22'h0, 1'b1, 22'h1);
    cyc("hlt3", 1'b0, 1'b1, 1'b0, 22'h0, 1'b0, 22'h0, 1'b1, 22'h1);
    cyc("hlt4", 1'b0, 1'b0, 1'b0, 22'h0, 1'b1, 22'h2, 1'b1, 22'h1);

    // Reset while the fetch of 0x2 is outstanding.
    stall = 1'b0; hlt = 1'b0;
    #3;
    chk("mid.req_before", 64'(bus.imem_req), 64'd1);
    rst = 1'b1;
    #1;
    chk("mid.req", 64'(bus.imem_req), 64'd0);
    chk("mid.instr", 64'(instr_IF), 64'(NOP_W));
    chk("mid.pc", 64'(PC_IF), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    wait_cfg = 0;
    cyc("rsm0", 1'b0, 1'b0, 1'b0, 22'h0, 1'b1, 22'h0, 1'b0, 22'h0);
    cyc("rsm1", 1'b0, 1'b0, 1'b0, 22'h0, 1'b1, 22'h1, 1'b1, 22'h0);

    // Randomized run against the stream model.
    do_reset();
    rand_mode = 1'b1;
    prev_out = 1'b0; abandoned = 1'b0; hold = 1'b0; expect_load = 1'b0;
    prev_addr = 22'd0; exp_pc = 22'd0; fetch_pc = 22'd0; hold_pc = 22'd0; load_pc = 22'd0;
    n_del = 0;
    for (int i = 0; i < 3000; i++) begin
      logic vld, acc, ack, exp_req;
      stall         = ($urandom_range(0, 3) == 0);
      hlt           = ($urandom_range(0, 7) == 0);
      branch_taken  = ($urandom_range(0, 15) == 0);
      branch_target = ($urandom_range(0, 1) == 0) ? 22'($urandom_range(0, 255))
                                                  : 22'h3FFFF8 + 22'($urandom_range(0, 7));
      rand_ack      = ($urandom_range(0, 2) != 0);
      #3;
      vld = (instr_IF != NOP_W);
      acc = !stall && !hlt;
      ack = bus.imem_req && bus.imem_ack;
      if (prev_out) begin
        chk("rnd.req_held", 64'(bus.imem_req), 64'd1);
        chk("rnd.addr_held", 64'(bus.imem_addr), 64'(prev_addr));
      end else begin
        exp_req = !hlt && (!vld || acc);
        chk("rnd.req_start", 64'(bus.imem_req), 64'(exp_req));
        if (exp_req) chk("rnd.fetch_addr", 64'(bus.imem_addr), 64'(fetch_pc));
      end
      if (expect_load) begin
        chk("rnd.load_vld", 64'(vld), 64'd1);
        chk("rnd.load_pc", 64'(PC_IF), 64'(load_pc));
      end
      if (hold) begin
        chk("rnd.hold_vld", 64'(vld), 64'd1);
        chk("rnd.hold_pc", 64'(PC_IF), 64'(hold_pc));
      end
      if (vld) begin
        chk("rnd.instr", 64'(instr_IF), 64'(mem_word(PC_IF)));
        chk("rnd.seq_pc", 64'(PC_IF), 64'(exp_pc));
      end else begin
        chk("rnd.pc_zero", 64'(PC_IF), 64'd0);
      end
      expect_load = ack && !abandoned && !branch_taken;
      load_pc     = bus.imem_addr;
      hold        = vld && !acc && !branch_taken;
      hold_pc     = PC_IF;
      if (vld && acc) begin
        exp_pc = PC_IF + 22'd1;
        n_del++;
      end
      if (expect_load) fetch_pc = bus.imem_addr + 22'd1;
      if (branch_taken) begin
        exp_pc   = branch_target;
        fetch_pc = branch_target;
      end
      if (branch_taken && bus.imem_req && !ack) abandoned = 1'b1;
      else if (ack) abandoned = 1'b0;
      prev_out  = bus.imem_req && !ack;
      prev_addr = bus.imem_addr;
      @(posedge clk); #1;
    end
    branch_taken = 1'b0;
    chk("rnd.progress", 64'(n_del >= 300), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
